imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Host-side writer for the instruction memory write port. Accepts a valid/ready word stream
//  (header: base byte address, word count; then payload words) and converts it into
//  registered write_addr/write_data/write_valid beats, one word per cycle, at consecutive
//  word addresses. Sits between the host/DMA ingress and imem. Reports busy, done and error.
// PARAMETERS
//  ADDRSIZE  256  imem depth in words; power of two; used for the overflow check
//  BITWIDTH  32   word width; also the address/count width
// PORTS
//  clock        in   1         clock
//  reset        in   1         reset, synchronous, active-high
//  in_data      in   BITWIDTH  stream word (header or payload)
//  in_valid     in   1         in_data valid
//  in_ready     out  1         loader accepts in_data this cycle
//  abort        in   1         sync abort; return to IDLE, drop the remaining payload
//  write_addr   out  BITWIDTH  imem byte write address (word aligned)
//  write_data   out  BITWIDTH  imem write data
//  write_valid  out  1         imem write strobe
//  busy         out  1         header or payload in progress
//  load_done    out  1         1-cycle pulse: last write issued (or count==0 header accepted)
//  load_error   out  1         sticky; cleared on the next accepted base word
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0; write_valid=0; write_addr=0; write_data=0; busy=0;
//   load_done=0; load_error=0; internal counters=0. Reset mid-load abandons the load, with no
//   further writes.
//  Handshake: word transfers when in_valid && in_ready. in_ready is a function of state only:
//   1 in IDLE/HDR_LEN/LOAD, 0 in DONE. imem never stalls, so no skid buffer is needed.
//  FSM:
//   IDLE    -> on transfer: base <= {in_data[BW-1:2],2'b0}; load_error <= (in_data[1:0]!=0);
//              go to HDR_LEN
//   HDR_LEN -> on transfer: remaining <= in_data; load_error |= (in_data > ADDRSIZE);
//              in_data==0 -> DONE; else -> LOAD
//   LOAD    -> on transfer: issue write at addr_ptr; addr_ptr += 4; remaining -= 1;
//              remaining==1 at transfer -> DONE
//   DONE    -> one cycle, load_done=1, -> IDLE
//  Write timing: payload accepted in cycle t -> write_valid=1 in t+1, with write_addr equal to
//   the pointer value at t and write_data equal to in_data at t. write_valid=0 in all other
//   cycles. Back-to-back payload produces back-to-back writes.
//  Address arithmetic: addr_ptr is BITWIDTH wide and wraps mod 2^BITWIDTH. imem applies its own
//   index masking. A count > ADDRSIZE flags load_error but all words are still written
//   (later words overwrite earlier ones).
//  Unaligned base: aligned down, load_error set, load proceeds.
//  load_done fires in the DONE cycle, one cycle after the last write transfer, coincident with
//   the final write_valid.
//  busy=1 in HDR_LEN, LOAD and DONE.
//  abort: has priority over any transfer in the same cycle (that word is not consumed, in_ready
//   is forced to 0). State -> IDLE, no load_done. A write already registered from the previous
//   cycle still completes. abort in IDLE has no effect.
//  in_valid low in any state: hold state, no writes.
// STRUCTURE
//  Shared package imem_pkg: loader_state_t enum {IDLE,HDR_LEN,LOAD,DONE}; WORD_BYTES=4 constant.
//  No sub-module. Single FSM, a remaining-count counter and an address pointer, plus a
//  registered write-port stage inline.
// TESTING
//  1 base=0x40, count=3, data A,B,C back-to-back -> writes (0x40,A),(0x44,B),(0x48,C) on three
//    consecutive cycles; load_done once; load_error=0
//  2 same stream with in_valid toggling 1/0 -> same three writes with gaps; state holds; one done
//  3 base=0x42, count=1, data D -> single write (0x40,D); load_error=1 until the next base word
//  4 count=0 -> no write_valid; load_done pulses in the cycle after count is accepted
//  5 count=ADDRSIZE+2 -> load_error=1, ADDRSIZE+2 writes issued, imem readback shows wrap overwrite
//  6 abort after 2 of 5 payload words, then new load base=0x0 count=1 -> exactly 2 + 1 writes;
//    no done for the aborted load; reset mid-LOAD -> all outputs 0 the next cycle

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader path.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HDR_LEN,
      LOAD,
      DONE
   } loader_state_t;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Converts a header+payload word stream into registered imem write beats,
// one word per cycle at consecutive word-aligned byte addresses.
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDRSIZE = 256,
   parameter int BITWIDTH = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [BITWIDTH-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                abort,
   output logic [BITWIDTH-1:0] write_addr,
   output logic [BITWIDTH-1:0] write_data,
   output logic                write_valid,
   output logic                busy,
   output logic                load_done,
   output logic                load_error
);

   localparam logic [BITWIDTH-1:0] ADDR_LIMIT = BITWIDTH'(ADDRSIZE);
   localparam logic [BITWIDTH-1:0] WORD_STEP  = BITWIDTH'(WORD_BYTES);

   loader_state_t       state;
   logic [BITWIDTH-1:0] remaining;
   logic [BITWIDTH-1:0] addr_ptr;
   logic                transfer;

   // Abort wins over a same-cycle transfer, so it withdraws ready outright.
   assign in_ready = !reset && !abort && (state != DONE);
   assign transfer = in_valid && in_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         remaining   <= '0;
         addr_ptr    <= '0;
         write_addr  <= '0;
         write_data  <= '0;
         write_valid <= 1'b0;
         busy        <= 1'b0;
         load_done   <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         write_valid <= 1'b0;
         load_done   <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (transfer) begin
                     addr_ptr   <= {in_data[BITWIDTH-1:2], 2'b00};
                     load_error <= |in_data[1:0];
                     state      <= HDR_LEN;
                     busy       <= 1'b1;
                  end
               end
               HDR_LEN: begin
                  if (transfer) begin
                     remaining <= in_data;
                     if (in_data > ADDR_LIMIT) begin
                        load_error <= 1'b1;
                     end
                     if (in_data == '0) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                     end else begin
                        state <= LOAD;
                     end
                  end
               end
               LOAD: begin
                  if (transfer) begin
                     write_valid <= 1'b1;
                     write_addr  <= addr_ptr;
                     write_data  <= in_data;
                     addr_ptr    <= addr_ptr + WORD_STEP;
                     remaining   <= remaining - 1'b1;
                     if (remaining == BITWIDTH'(1)) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized loads against a load-level reference model.
module tb_imem_loader;

   localparam int ADDRSIZE = 256;
   localparam int BW       = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic [BW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          abort;
   logic [BW-1:0] write_addr;
   logic [BW-1:0] write_data;
   logic          write_valid;
   logic          busy;
   logic          load_done;
   logic          load_error;

   imem_loader #(.ADDRSIZE(ADDRSIZE), .BITWIDTH(BW)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .abort       (abort),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .write_valid (write_valid),
      .busy        (busy),
      .load_done   (load_done),
      .load_error  (load_error)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [BW-1:0] addr;
      logic [BW-1:0] data;
      int            at;
   } wr_t;

   typedef struct {
      int at;
      bit with_write;
   } done_t;

   wr_t           exp_wr[$];
   done_t         exp_done[$];
   logic [BW-1:0] tb_mem [ADDRSIZE];
   logic [BW-1:0] exp_mem[ADDRSIZE];
   int            checks   = 0;
   int            errors   = 0;
   int            n_writes = 0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write or a done pulse.
   always @(negedge clock) begin
      wr_t   e;
      done_t d;
      if (write_valid === 1'b1) begin
         n_writes++;
         tb_mem[int'((write_addr >> 2) & BW'(ADDRSIZE - 1))] = write_data;
         $display("write cyc=%0d addr=%h data=%h", cyc, write_addr, write_data);
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h required=none", write_addr);
         end else begin
            e = exp_wr.pop_front();
            check("write_addr", write_addr, e.addr);
            check("write_data", write_data, e.data);
            check("write_cycle", BW'(cyc), BW'(e.at));
         end
      end
      if (load_done === 1'b1) begin
         $display("done  cyc=%0d error=%b", cyc, load_error);
         if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            d = exp_done.pop_front();
            check("done_cycle", BW'(cyc), BW'(d.at));
            if (d.with_write) check("done_with_write", BW'(write_valid), 1);
         end
      end
   end

   // Offers one word after an optional idle gap (gap_max < 0 forces a single idle cycle).
   task automatic send(input logic [BW-1:0] w, input int gap_max, output bit ok);
      int gap;
      gap = (gap_max < 0) ? 1 : ((gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clock);
         #1;
      end
      in_valid = 1'b1;
      in_data  = w;
      ok       = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         ok = in_ready;
         @(posedge clock);
         #1;
         if (ok) break;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout actual=no_ready required=ready word=%h", w);
      end
   endtask

   // Reference load: aligned base + 4*i per word, error if base unaligned or count exceeds depth.
   task automatic do_load(input logic [BW-1:0] base, input logic [BW-1:0] count,
                          input int gap, input int abort_after);
      logic [BW-1:0] ptr;
      logic [BW-1:0] d;
      logic [BW-1:0] ix;
      bit            err;
      bit            ok;
      ptr = {base[BW-1:2], 2'b00};
      err = (base[1:0] != 2'b00) || (count > BW'(ADDRSIZE));
      send(base, gap, ok);
      check("error_after_base", BW'(load_error), BW'(base[1:0] != 2'b00));
      check("busy_after_base", BW'(busy), 1);
      send(count, gap, ok);
      if (count == 0) exp_done.push_back('{cyc, 1'b0});
      check("error_after_count", BW'(load_error), BW'(err));
      for (int i = 0; i < int'(count); i++) begin
         if (i == abort_after) begin
            abort    = 1'b1;
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clock);
            check("ready_during_abort", BW'(in_ready), 0);
            @(posedge clock);
            #1;
            abort    = 1'b0;
            in_valid = 1'b0;
            check("busy_after_abort", BW'(busy), 0);
            return;
         end
         d = $urandom;
         send(d, gap, ok);
         if (ok) begin
            exp_wr.push_back('{ptr, d, cyc});
            ix = (base >> 2) + BW'(i);
            exp_mem[int'(ix % BW'(ADDRSIZE))] = d;
            ptr = ptr + 4;
         end
         if (i == int'(count) - 1) exp_done.push_back('{cyc, 1'b1});
      end
      check("error_after_load", BW'(load_error), BW'(err));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w0;
      bit  ok;
      logic [BW-1:0] d;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      abort    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      @(negedge clock);
      check("reset_in_ready", BW'(in_ready), 0);
      check("reset_write_valid", BW'(write_valid), 0);
      check("reset_write_addr", write_addr, 0);
      check("reset_write_data", write_data, 0);
      check("reset_busy", BW'(busy), 0);
      check("reset_load_done", BW'(load_done), 0);
      check("reset_load_error", BW'(load_error), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Back-to-back load, then the same with in_valid toggling.
      do_load(32'h40, 3, 0, -1);
      do_load(32'h40, 3, -1, -1);
      // Unaligned base, then a zero-count header that also clears the error.
      do_load(32'h42, 1, 0, -1);
      do_load(32'h0, 0, 0, -1);

      // Overflowing count wraps around imem and overwrites the first words.
      for (int i = 0; i < ADDRSIZE; i++) begin
         tb_mem[i]  = '0;
         exp_mem[i] = '0;
      end
      do_load(32'h100, BW'(ADDRSIZE + 2), 0, -1);
      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < ADDRSIZE; i++) check("mem_readback", tb_mem[i], exp_mem[i]);

      // Abort after two of five words, then a fresh one-word load.
      w0 = n_writes;
      do_load(32'h200, 5, 0, 2);
      check("abort_in_idle_busy", BW'(busy), 0);
      do_load(32'h0, 1, 0, -1);
      repeat (2) @(posedge clock);
      #1;
      check("abort_write_count", BW'(n_writes - w0), 3);

      // Randomized loads with random gaps and possibly unaligned bases.
      for (int n = 0; n < 8; n++) do_load($urandom, BW'($urandom_range(6, 0)), 2, -1);

      // Reset in the middle of a load: the registered write completes, nothing after.
      send(32'h80, 0, ok);
      send(32'd4, 0, ok);
      for (int i = 0; i < 2; i++) begin
         d = $urandom;
         send(d, 0, ok);
         exp_wr.push_back('{32'h80 + BW'(4 * i), d, cyc});
      end
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clock);
      #1;
      @(negedge clock);
      check("midreset_in_ready", BW'(in_ready), 0);
      check("midreset_write_valid", BW'(write_valid), 0);
      check("midreset_write_addr", write_addr, 0);
      check("midreset_write_data", write_data, 0);
      check("midreset_busy", BW'(busy), 0);
      check("midreset_load_done", BW'(load_done), 0);
      check("midreset_load_error", BW'(load_error), 0);
      @(posedge clock);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;

      repeat (4) @(posedge clock);
      #1;
      check("writes_outstanding", BW'(exp_wr.size()), 0);
      check("dones_outstanding", BW'(exp_done.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
